button_toggle_switch: RTL and testbench
=======================================

BUTTON_TOGGLE_SWITCH -- requirements
Module: button_toggle_switch

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100000, meaning consecutive stable cycles required to accept a level change; legal range >= 2.
REQ-002 SHALL have port i_clk, input, 1 bit, single clock for all sequential logic.
REQ-003 SHALL have port i_reset, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port i_button, input, 1 bit, raw asynchronous pushbutton, 1 = pressed, may bounce.
REQ-005 SHALL have port o_OnOffSW, output, 1 bit, toggled switch level driven directly into the light FSM switch input.
REQ-006 SHALL have port o_btn_stable, output, 1 bit, debounced button level.
REQ-007 SHALL have port o_press_pulse, output, 1 bit, one-cycle strobe on each accepted press.

Function
REQ-008 SHALL pass i_button through a two-flop synchronizer; only the second flop output (btn_sync) feeds the FSM.
REQ-009 SHALL implement four states: S_RELEASED, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT.
REQ-010 S_RELEASED: btn_sync=1 -> S_PRESS_WAIT with counter cleared to 0; else stay.
REQ-011 S_PRESS_WAIT: btn_sync=1 -> counter increments; btn_sync=0 on any cycle -> S_RELEASED, counter cleared, no output change.
REQ-012 S_PRESS_WAIT: when btn_sync=1 and counter = DEBOUNCE_CYCLES-1 -> S_PRESSED; on that same edge o_OnOffSW inverts, o_press_pulse=1, o_btn_stable=1.
REQ-013 S_PRESSED: btn_sync=0 -> S_RELEASE_WAIT with counter cleared; else stay; holding the button SHALL NOT cause further toggles.
REQ-014 S_RELEASE_WAIT: btn_sync=0 -> counter increments; btn_sync=1 -> S_PRESSED, counter cleared.
REQ-015 S_RELEASE_WAIT: when btn_sync=0 and counter = DEBOUNCE_CYCLES-1 -> S_RELEASED; o_btn_stable=0 on that edge; o_OnOffSW unchanged.
REQ-016 Latency: for a clean press, o_OnOffSW SHALL change exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling i_button=1.
REQ-017 o_press_pulse SHALL be high for exactly one cycle per accepted press and low otherwise.
REQ-018 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); counter SHALL never wrap (cleared on every state entry, compared before overflow).
REQ-019 Any bounce shorter than DEBOUNCE_CYCLES cycles SHALL be rejected with no output change.
REQ-020 All outputs SHALL be registered; no combinational path from i_button to any output.
REQ-021 Unused state encodings SHALL recover to S_RELEASED on the next edge.

Reset
REQ-022 Assertion of i_reset (low) SHALL asynchronously force state S_RELEASED, counter 0, synchronizer flops 0, o_OnOffSW=0, o_btn_stable=0, o_press_pulse=0.
REQ-023 Reset asserted mid-debounce or while pressed SHALL discard progress; after release a still-held button SHALL require a full new debounce window before toggling.
REQ-024 o_OnOffSW=0 after reset SHALL correspond to the light-off state of the downstream light FSM.

Structure
REQ-025 State encodings and the DEBOUNCE_CYCLES default SHALL live in a shared package, fsm_pkg.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports i_clk, i_reset, i_d, o_q.
REQ-027 Implementation SHALL use separate state-register, next-state, and output blocks; total RTL 120-400 lines.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean press: reset, i_button 0->1 held 20 cycles -> o_OnOffSW 0->1 exactly 6 edges after first sampled 1; one o_press_pulse; o_btn_stable=1.
REQ-029 Bounce: i_button toggles 1,0,1,0 each cycle then 0 -> no change on any output.
REQ-030 Two full press/release cycles (hold 10, release 10) -> o_OnOffSW 0->1->0; exactly two o_press_pulse strobes.
REQ-031 Hold 100 cycles -> single toggle, single pulse; release glitch of 2 cycles mid-hold -> no second toggle.
REQ-032 Reset asserted (low) 3 cycles into S_PRESS_WAIT and again while S_PRESSED with o_OnOffSW=1 -> all outputs 0 immediately; button still held after release -> toggle to 1 only after 6 further edges.
REQ-033 Connected to the light FSM: press once -> light on; press again -> light off.

Source files
------------

// File: rtl/fsm_pkg.sv
// ============================================================================
// Module : fsm_pkg
// Brief  : Shared state encodings and debounce default for the button toggle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fsm_pkg;

    localparam int unsigned C_DEBOUNCE_CYCLES_DEFAULT = 100000;

    typedef enum logic [1:0] {
        S_RELEASED     = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_PRESSED      = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage : fsm_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : Two-flop synchronizer for a single asynchronous level.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/button_toggle_switch.sv
// ============================================================================
// Module : button_toggle_switch
// Brief  : Debounced pushbutton that flips a registered on/off switch per press.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module button_toggle_switch
    import fsm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_button,
    output logic o_OnOffSW,
    output logic o_btn_stable,
    output logic o_press_pulse
);

    localparam int unsigned           C_CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0]    C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               w_btn_sync;
    btn_state_t         r_state;
    btn_state_t         w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_accept_press;
    logic               w_accept_release;
    logic               r_onoff;
    logic               r_stable;
    logic               r_pulse;

    sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_button),
        .o_q     (w_btn_sync)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_RELEASED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Counter is cleared on every state change and compared before it can wrap.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            S_RELEASED: begin
                if (w_btn_sync) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!w_btn_sync) begin
                    w_state_nxt = S_RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt    = S_PRESSED;
                    w_cnt_nxt      = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!w_btn_sync) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (w_btn_sync) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt      = S_RELEASED;
                    w_cnt_nxt        = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_onoff  <= 1'b0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= w_accept_press;
            if (w_accept_press) begin
                r_onoff  <= ~r_onoff;
                r_stable <= 1'b1;
            end else if (w_accept_release) begin
                r_stable <= 1'b0;
            end
        end
    end

    assign o_OnOffSW     = r_onoff;
    assign o_btn_stable  = r_stable;
    assign o_press_pulse = r_pulse;

endmodule : button_toggle_switch

`default_nettype wire

// File: tb/tb_button_toggle_switch.sv
// ============================================================================
// Module : tb_button_toggle_switch
// Brief  : Scoreboard bench with a run-length debounce reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_button_toggle_switch;

    localparam int DEB = 4;

    typedef struct {
        int   cyc;
        logic val;
    } press_t;

    logic clk;
    logic i_reset;
    logic i_button;
    logic o_OnOffSW;
    logic o_btn_stable;
    logic o_press_pulse;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;

    // Reference model: level is accepted once the synchronized input has
    // disagreed with the stable level for DEB+1 consecutive samples.
    logic m_s1, m_s2, m_stable, m_onoff;
    int   m_run;
    press_t exp_q[$];

    button_toggle_switch #(.DEBOUNCE_CYCLES(DEB)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_button      (i_button),
        .o_OnOffSW     (o_OnOffSW),
        .o_btn_stable  (o_btn_stable),
        .o_press_pulse (o_press_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_stable = 0; m_onoff = 0; m_run = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic b);
        logic fsm_in;
        fsm_in = m_s2;
        m_s2   = m_s1;
        m_s1   = b;
        if (fsm_in != m_stable) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_stable = fsm_in;
                m_run    = 0;
                if (fsm_in) begin
                    m_onoff = ~m_onoff;
                    exp_q.push_back('{cyc: cyc, val: m_onoff});
                end
            end
        end else begin
            m_run = 0;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic drive(input logic b);
        i_button = b;
        @(posedge clk);
        cyc++;
        model_step(b);
        @(negedge clk);
    endtask

    task automatic drive_n(input logic b, input int n);
        for (int k = 0; k < n; k++) drive(b);
    endtask

    task automatic pulse_reset(input int n);
        #1 i_reset = 1'b0;
        #1;
        check("rst_onoff",  int'(o_OnOffSW),     0);
        check("rst_stable", int'(o_btn_stable),  0);
        check("rst_pulse",  int'(o_press_pulse), 0);
        model_reset();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    // Monitor: pops on each strobe, flags missed strobes, tracks levels.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (o_press_pulse) begin
                pulse_cnt++;
                last_pulse_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", 1, 0);
                end else begin
                    press_t e;
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_onoff", int'(o_OnOffSW), int'(e.val));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                check("missed_pulse", 0, 1);
                void'(exp_q.pop_front());
            end
            check("onoff_level",  int'(o_OnOffSW),    int'(m_onoff));
            check("stable_level", int'(o_btn_stable), int'(m_stable));
        end
    end

    initial begin
        int p0;
        int c0;
        logic lvl;
        i_reset  = 1'b0;
        i_button = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_onoff",  int'(o_OnOffSW),     0);
        check("init_stable", int'(o_btn_stable),  0);
        check("init_pulse",  int'(o_press_pulse), 0);
        i_reset = 1'b1;
        drive_n(1'b0, 3);

        // Clean press: toggle exactly DEB+2 edges after first sampled 1.
        p0 = pulse_cnt;
        c0 = cyc + 1;
        drive_n(1'b1, 20);
        check("clean_latency", last_pulse_cyc, c0 + DEB + 2);
        check("clean_pulses",  pulse_cnt - p0, 1);
        check("clean_onoff",   int'(o_OnOffSW), 1);
        check("clean_stable",  int'(o_btn_stable), 1);
        drive_n(1'b0, 20);
        check("clean_released", int'(o_btn_stable), 0);

        // Bounce shorter than the window.
        p0 = pulse_cnt;
        drive(1'b1); drive(1'b0); drive(1'b1); drive(1'b0);
        drive_n(1'b0, 10);
        check("bounce_pulses", pulse_cnt - p0, 0);
        check("bounce_onoff",  int'(o_OnOffSW), 1);

        // Two full press/release cycles.
        p0 = pulse_cnt;
        for (int k = 0; k < 2; k++) begin
            drive_n(1'b1, 10);
            drive_n(1'b0, 10);
        end
        check("two_press_pulses", pulse_cnt - p0, 2);
        check("two_press_onoff",  int'(o_OnOffSW), 1);

        // Long hold with a short release glitch.
        p0 = pulse_cnt;
        drive_n(1'b1, 50);
        drive_n(1'b0, 2);
        drive_n(1'b1, 48);
        drive_n(1'b0, 20);
        check("hold_pulses", pulse_cnt - p0, 1);
        check("hold_onoff",  int'(o_OnOffSW), 0);

        // Reset three cycles into the press window, button still held.
        drive_n(1'b1, 5);
        pulse_reset(3);
        p0 = pulse_cnt;
        c0 = cyc + 1;
        drive_n(1'b1, 12);
        check("rst_wait_latency", last_pulse_cyc, c0 + DEB + 2);
        check("rst_wait_onoff",   int'(o_OnOffSW), 1);

        // Reset while pressed with the switch on.
        pulse_reset(3);
        c0 = cyc + 1;
        drive_n(1'b1, 12);
        check("rst_pressed_latency", last_pulse_cyc, c0 + DEB + 2);
        check("rst_pressed_pulses",  pulse_cnt - p0, 2);
        drive_n(1'b0, 12);

        // Randomized level segments.
        for (int k = 0; k < 300; k++) begin
            lvl = 1'($urandom_range(0, 1));
            drive_n(lvl, int'($urandom_range(1, 9)));
        end
        drive_n(1'b0, 12);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_button_toggle_switch

`default_nettype wire
